// File: rtl/sram_controller.sv
// Memory-mapped sequencer for a 256Kx16 async SRAM: the CPU loads ADDR/DATA and writes GO,
// then one registered SETUP/ACCESS/HOLD cycle runs on the SRAM pins while busy is reported.
module sram_controller #(
    parameter int WAIT_CYCLES = 1,
    parameter int ADDR_W      = 18
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [15:0]       in,
    input  logic              loadAddr,
    input  logic              loadData,
    input  logic              loadGo,
    output logic [15:0]       outAddr,
    output logic [15:0]       outData,
    output logic [15:0]       outStatus,
    output logic [ADDR_W-1:0] sram_addr,
    input  logic [15:0]       sram_dq_in,
    output logic [15:0]       sram_dq_out,
    output logic              sram_dq_oe,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n,
    output logic              sram_ub_n,
    output logic              sram_lb_n
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, HOLD} state_t;
    localparam int CNT_W = $clog2(WAIT_CYCLES + 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d, pin_addr_q, pin_addr_d;
    logic [15:0]       data_q, data_d, dq_out_q, dq_out_d;
    logic              op_q, op_d, inc_q, inc_d;
    logic              busy_q, busy_d, done_q, done_d, ovr_q, ovr_d;
    logic              ce_n_q, ce_n_d, oe_n_q, oe_n_d, we_n_q, we_n_d;
    logic              ub_n_q, ub_n_d, lb_n_q, lb_n_d, dq_oe_q, dq_oe_d;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            pin_addr_q <= '0;
            data_q     <= '0;
            dq_out_q   <= '0;
            op_q       <= 1'b0;
            inc_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ovr_q      <= 1'b0;
            ce_n_q     <= 1'b1;
            oe_n_q     <= 1'b1;
            we_n_q     <= 1'b1;
            ub_n_q     <= 1'b1;
            lb_n_q     <= 1'b1;
            dq_oe_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            pin_addr_q <= pin_addr_d;
            data_q     <= data_d;
            dq_out_q   <= dq_out_d;
            op_q       <= op_d;
            inc_q      <= inc_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            ovr_q      <= ovr_d;
            ce_n_q     <= ce_n_d;
            oe_n_q     <= oe_n_d;
            we_n_q     <= we_n_d;
            ub_n_q     <= ub_n_d;
            lb_n_q     <= lb_n_d;
            dq_oe_q    <= dq_oe_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        pin_addr_d = pin_addr_q;
        data_d     = data_q;
        dq_out_d   = dq_out_q;
        op_d       = op_q;
        inc_d      = inc_q;
        busy_d     = busy_q;
        done_d     = done_q;
        ovr_d      = ovr_q;
        ce_n_d     = ce_n_q;
        oe_n_d     = oe_n_q;
        we_n_d     = we_n_q;
        ub_n_d     = ub_n_q;
        lb_n_d     = lb_n_q;
        dq_oe_d    = dq_oe_q;

        // Operands are only writable while idle so an in-flight transaction stays frozen.
        if (state_q == IDLE) begin
            if (loadAddr) addr_d[15:0] = in;
            if (loadData) data_d = in;
        end else if (loadGo) begin
            ovr_d = 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (loadGo) begin
                    op_d        = in[0];
                    inc_d       = in[1];
                    addr_d[17:16] = in[3:2];
                    pin_addr_d  = {in[3:2], addr_q[15:0]};
                    busy_d      = 1'b1;
                    done_d      = 1'b0;
                    ovr_d       = 1'b0;
                    ce_n_d      = 1'b0;
                    ub_n_d      = in[0] ? 1'b0 : in[4];
                    lb_n_d      = in[0] ? 1'b0 : in[5];
                    dq_oe_d     = ~in[0];
                    dq_out_d    = data_q;
                    state_d     = SETUP;
                end
            end
            SETUP: begin
                cnt_d   = CNT_W'(WAIT_CYCLES - 1);
                oe_n_d  = ~op_q;
                we_n_d  = op_q;
                state_d = ACCESS;
            end
            ACCESS: begin
                if (cnt_q == '0) begin
                    oe_n_d  = 1'b1;
                    we_n_d  = 1'b1;
                    if (op_q) data_d = sram_dq_in;
                    state_d = HOLD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            HOLD: begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                ce_n_d  = 1'b1;
                ub_n_d  = 1'b1;
                lb_n_d  = 1'b1;
                dq_oe_d = 1'b0;
                if (inc_q) addr_d = addr_q + ADDR_W'(1);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign outAddr     = addr_q[15:0];
    assign outData     = data_q;
    assign outStatus   = {busy_q, done_q, ovr_q, 11'b0, addr_q[17:16]};
    assign sram_addr   = pin_addr_q;
    assign sram_dq_out = dq_out_q;
    assign sram_dq_oe  = dq_oe_q;
    assign sram_ce_n   = ce_n_q;
    assign sram_oe_n   = oe_n_q;
    assign sram_we_n   = we_n_q;
    assign sram_ub_n   = ub_n_q;
    assign sram_lb_n   = lb_n_q;

endmodule
